// File: rtl/poly_synth_pkg.sv
// rtl/poly_synth_pkg.sv - shared types and sizes for the polyphonic voice path
package poly_synth_pkg;

    localparam int NUM_VOICES  = 16;
    localparam int NOTE_W      = 7;
    localparam int VOICE_IDX_W = $clog2(NUM_VOICES);

    typedef logic [NOTE_W-1:0] note_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        COMMIT = 2'd2
    } state_t;

endpackage

// File: rtl/poly_voice_slot.sv
// rtl/poly_voice_slot.sv - one voice slot: note, active and (POLY_SUSTAIN_EN) held bits
module poly_voice_slot #(
    parameter int NOTE_W = poly_synth_pkg::NOTE_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic              set,
    input  logic              clr,
`ifdef POLY_SUSTAIN_EN
    input  logic              hold,
    input  logic              release_en,
`endif
    input  logic [NOTE_W-1:0] note_in,
    output logic [NOTE_W-1:0] note,
    output logic              active
);
    import poly_synth_pkg::*;

`ifdef POLY_SUSTAIN_EN
    logic held;

    // Pedal release and commit strobes never overlap: release only fires in IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            note   <= '0;
            active <= 1'b0;
            held   <= 1'b0;
        end else begin
            if (we) note <= note_in;
            if (release_en && held) begin
                active <= 1'b0;
                held   <= 1'b0;
            end else if (set) begin
                active <= 1'b1;
                held   <= 1'b0;
            end else if (clr) begin
                active <= 1'b0;
                held   <= 1'b0;
            end else if (hold) begin
                held   <= 1'b1;
            end
        end
    end
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            note   <= '0;
            active <= 1'b0;
        end else begin
            if (we) note <= note_in;
            if (set)      active <= 1'b1;
            else if (clr) active <= 1'b0;
        end
    end
`endif

endmodule

// File: rtl/poly_voice_allocator.sv
// rtl/poly_voice_allocator.sv - serial-scan note-on/off voice allocator (sustain pedal via POLY_SUSTAIN_EN)
module poly_voice_allocator #(
    parameter int NUM_VOICES = poly_synth_pkg::NUM_VOICES,
    parameter int NOTE_W     = poly_synth_pkg::NOTE_W
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           event_valid,
    output logic                           event_ready,
    input  logic                           event_on,
    input  logic [NOTE_W-1:0]              event_note,
`ifdef POLY_SUSTAIN_EN
    input  logic                           sustain,
`endif
    output logic [NUM_VOICES*NOTE_W-1:0]   notes,
    output logic [NUM_VOICES-1:0]          active,
    output logic                           done,
    output logic [$clog2(NUM_VOICES)-1:0]  done_voice,
    output logic                           stolen
);
    import poly_synth_pkg::*;

    localparam int               IDX_W    = $clog2(NUM_VOICES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

    state_t            state, state_nxt;
    logic              ready_en;
    logic              accept;
    logic [IDX_W-1:0]  idx, steal_ptr, match_idx, free_idx, tgt_idx;
    logic              match_found, free_found;
    logic              cap_on;
    logic [NOTE_W-1:0] cap_note;
    logic              do_write, do_set, do_clr, do_steal;
    logic [NOTE_W-1:0] slot_note [NUM_VOICES];
    logic [NUM_VOICES-1:0] slot_active;
`ifdef POLY_SUSTAIN_EN
    logic              do_hold;
    logic              release_en;
    assign release_en = (state == IDLE) && !sustain;
`endif

    // ready_en keeps the handshake closed until the first clock after reset.
    assign event_ready = ready_en && (state == IDLE);
    assign accept      = event_valid && event_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SCAN;
            SCAN:    if (idx == LAST_IDX) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Commit decision from the scan results: match, then lowest free, then steal.
    always_comb begin
        tgt_idx  = '0;
        do_write = 1'b0;
        do_set   = 1'b0;
        do_clr   = 1'b0;
        do_steal = 1'b0;
`ifdef POLY_SUSTAIN_EN
        do_hold  = 1'b0;
`endif
        if (cap_on) begin
            do_set = 1'b1;
            if (match_found) begin
                tgt_idx = match_idx;
            end else if (free_found) begin
                tgt_idx  = free_idx;
                do_write = 1'b1;
            end else begin
                tgt_idx  = steal_ptr;
                do_write = 1'b1;
                do_steal = 1'b1;
            end
        end else if (match_found) begin
            tgt_idx = match_idx;
`ifdef POLY_SUSTAIN_EN
            if (sustain) do_hold = 1'b1;
            else         do_clr  = 1'b1;
`else
            do_clr = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_en    <= 1'b0;
            idx         <= '0;
            steal_ptr   <= '0;
            match_idx   <= '0;
            free_idx    <= '0;
            match_found <= 1'b0;
            free_found  <= 1'b0;
            cap_on      <= 1'b0;
            cap_note    <= '0;
            done        <= 1'b0;
            done_voice  <= '0;
            stolen      <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            done     <= 1'b0;
            stolen   <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        cap_on      <= event_on;
                        cap_note    <= event_note;
                        idx         <= '0;
                        match_found <= 1'b0;
                        free_found  <= 1'b0;
                    end
                end
                SCAN: begin
                    if (!match_found && slot_active[idx] && (slot_note[idx] == cap_note)) begin
                        match_found <= 1'b1;
                        match_idx   <= idx;
                    end
                    if (!free_found && !slot_active[idx]) begin
                        free_found <= 1'b1;
                        free_idx   <= idx;
                    end
                    idx <= idx + IDX_W'(1);
                end
                COMMIT: begin
                    done       <= 1'b1;
                    done_voice <= tgt_idx;
                    stolen     <= do_steal;
                    if (do_steal) steal_ptr <= steal_ptr + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_VOICES; i++) begin : g_slot
        logic sel;
        assign sel = (state == COMMIT) && (tgt_idx == IDX_W'(i));

        poly_voice_slot #(.NOTE_W(NOTE_W)) u_slot (
            .clk        (clk),
            .reset      (reset),
            .we         (sel && do_write),
            .set        (sel && do_set),
            .clr        (sel && do_clr),
`ifdef POLY_SUSTAIN_EN
            .hold       (sel && do_hold),
            .release_en (release_en),
`endif
            .note_in    (cap_note),
            .note       (slot_note[i]),
            .active     (slot_active[i])
        );

        assign notes[i*NOTE_W +: NOTE_W] = slot_note[i];
    end

    assign active = slot_active;

endmodule

// File: tb/tb_poly_voice_allocator.sv
// tb/tb_poly_voice_allocator.sv - directed vector bench for poly_voice_allocator (POLY_SUSTAIN_EN adds pedal checks)
module tb_poly_voice_allocator;

    logic         clk = 1'b0;
    logic         reset;
    logic         event_valid;
    logic         event_ready;
    logic         event_on;
    logic [6:0]   event_note;
    logic [111:0] notes;
    logic [15:0]  active;
    logic         done;
    logic [3:0]   done_voice;
    logic         stolen;
`ifdef POLY_SUSTAIN_EN
    logic         sustain;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    poly_voice_allocator dut (
        .clk         (clk),
        .reset       (reset),
        .event_valid (event_valid),
        .event_ready (event_ready),
        .event_on    (event_on),
        .event_note  (event_note),
`ifdef POLY_SUSTAIN_EN
        .sustain     (sustain),
`endif
        .notes       (notes),
        .active      (active),
        .done        (done),
        .done_voice  (done_voice),
        .stolen      (stolen)
    );

    typedef struct packed {
        logic        rst;
        logic        on;
        logic [6:0]  note;
        logic [3:0]  voice;
        logic        stl;
        logic [15:0] act;
        logic [6:0]  exp_note;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act_v, exp_v);
        end
    endtask

    function automatic logic [6:0] slot_note(input int i);
        return notes[i*7 +: 7];
    endfunction

    // Entered and left at #1 after a rising edge.
    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Returns the number of edges from the accept edge (counted as 1) until done is seen.
    task automatic send(input logic on, input logic [6:0] note, output int lat);
        int w;
        w = 0;
        while (!event_ready && w < 50) begin
            @(posedge clk);
            #1 w++;
        end
        check("ready_before_send", event_ready, 1);
        event_on    = on;
        event_note  = note;
        event_valid = 1'b1;
        @(posedge clk);
        #1 lat = 1;
        event_valid = 1'b0;
        event_on    = ~on;
        event_note  = 7'h55;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
    endtask

    int lat;

    initial begin
        reset       = 1'b1;
        event_valid = 1'b0;
        event_on    = 1'b0;
        event_note  = '0;
`ifdef POLY_SUSTAIN_EN
        sustain     = 1'b0;
`endif
        #12;
        check("rst_ready",  event_ready, 0);
        check("rst_active", active, 0);
        check("rst_notes",  notes[31:0], 0);
        check("rst_done",   done, 0);
        check("rst_stolen", stolen, 0);
        check("rst_voice",  done_voice, 0);

        vecs[0] = '{1'b1, 1'b1, 7'd60, 4'd0, 1'b0, 16'h0001, 7'd60};
        vecs[1] = '{1'b0, 1'b1, 7'd64, 4'd1, 1'b0, 16'h0003, 7'd64};
        vecs[2] = '{1'b0, 1'b1, 7'd67, 4'd2, 1'b0, 16'h0007, 7'd67};
        vecs[3] = '{1'b0, 1'b0, 7'd64, 4'd1, 1'b0, 16'h0005, 7'd64};
        vecs[4] = '{1'b0, 1'b1, 7'd72, 4'd1, 1'b0, 16'h0007, 7'd72};
        vecs[5] = '{1'b0, 1'b1, 7'd60, 4'd0, 1'b0, 16'h0007, 7'd60};
        vecs[6] = '{1'b0, 1'b0, 7'd99, 4'd0, 1'b0, 16'h0007, 7'd60};
        vecs[7] = '{1'b1, 1'b1, 7'd60, 4'd0, 1'b0, 16'h0001, 7'd60};
        vecs[8] = '{1'b0, 1'b1, 7'd60, 4'd0, 1'b0, 16'h0001, 7'd60};

        for (int v = 0; v < 9; v++) begin
            if (vecs[v].rst) do_reset();
            send(vecs[v].on, vecs[v].note, lat);
            check($sformatf("v%0d_latency", v), lat, 18);
            check($sformatf("v%0d_done", v), done, 1);
            check($sformatf("v%0d_voice", v), done_voice, vecs[v].voice);
            check($sformatf("v%0d_stolen", v), stolen, vecs[v].stl);
            check($sformatf("v%0d_active", v), active, vecs[v].act);
            check($sformatf("v%0d_note", v), slot_note(int'(vecs[v].voice)), vecs[v].exp_note);
            @(posedge clk);
            #1 check($sformatf("v%0d_done_pulse", v), done, 0);
        end

        // Fill all 16 slots, then exercise stealing and steal_ptr advance.
        do_reset();
        for (int n = 0; n < 16; n++) begin
            send(1'b1, 7'(n), lat);
            check($sformatf("fill%0d_voice", n), done_voice, n);
        end
        check("fill_active", active, 16'hffff);
        send(1'b1, 7'd16, lat);
        check("steal1_stolen", stolen, 1);
        check("steal1_voice",  done_voice, 0);
        check("steal1_note",   slot_note(0), 16);
        send(1'b1, 7'd20, lat);
        check("steal2_stolen", stolen, 1);
        check("steal2_voice",  done_voice, 1);
        check("steal2_note",   slot_note(1), 20);
        send(1'b1, 7'd16, lat);
        check("retrig_stolen", stolen, 0);
        check("retrig_voice",  done_voice, 0);
        send(1'b0, 7'd20, lat);
        check("off20_voice",  done_voice, 1);
        check("off20_active", active, 16'hfffd);
        send(1'b1, 7'd30, lat);
        check("free_stolen", stolen, 0);
        check("free_voice",  done_voice, 1);
        check("free_note",   slot_note(1), 30);
        send(1'b1, 7'd31, lat);
        check("steal3_stolen", stolen, 1);
        check("steal3_voice",  done_voice, 2);
        check("steal3_note",   slot_note(2), 31);

        // Asynchronous reset in the middle of a scan.
        event_on    = 1'b1;
        event_note  = 7'd40;
        event_valid = 1'b1;
        @(posedge clk);
        #1 event_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("midrst_active", active, 0);
        check("midrst_notes",  notes[31:0], 0);
        check("midrst_ready",  event_ready, 0);
        check("midrst_done",   done, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        check("midrst_ready_pre", event_ready, 0);
        @(posedge clk);
        #1 check("midrst_ready_post", event_ready, 1);
        check("midrst_no_commit", done, 0);
        send(1'b1, 7'd40, lat);
        check("post_rst_latency", lat, 18);
        check("post_rst_voice",   done_voice, 0);
        check("post_rst_active",  active, 16'h0001);

`ifdef POLY_SUSTAIN_EN
        do_reset();
        sustain = 1'b1;
        send(1'b1, 7'd60, lat);
        check("sus_on_active", active, 16'h0001);
        send(1'b0, 7'd60, lat);
        check("sus_off_voice",  done_voice, 0);
        check("sus_off_active", active, 16'h0001);
        sustain = 1'b0;
        @(posedge clk);
        #1 check("sus_release_active", active, 16'h0000);
        sustain = 1'b1;
        send(1'b1, 7'd62, lat);
        send(1'b0, 7'd62, lat);
        send(1'b1, 7'd62, lat);
        check("sus_retrig_voice", done_voice, 0);
        sustain = 1'b0;
        @(posedge clk);
        #1 check("sus_retrig_kept", active, 16'h0001);
        send(1'b0, 7'd62, lat);
        check("sus_plain_off", active, 16'h0000);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/poly_voice_allocator.md
Name: poly_voice_allocator

Overview:
- Accepts note-on/note-off events, one at a time through a valid/ready handshake.
- Assigns each event to one of NUM_VOICES voice slots.
- Drives the per-voice note numbers and an active mask consumed by the polyphonic frequency lookup and the oscillator bank.
- Scans slots serially, one slot per clock, to keep area small.

Parameters:
- NUM_VOICES, 16, number of voice slots; power of two, 2..16.
- NOTE_W, 7, note number width; C0 = 0, C#0 = 1, etc.

Ports:
- clk  input  1  clock
- reset  input  1  reset, asynchronous, active-high
- event_valid  input  1  event present
- event_ready  output  1  allocator can accept an event
- event_on  input  1  1 = note-on, 0 = note-off
- event_note  input  NOTE_W  note number of the event
- notes  output  NUM_VOICES*NOTE_W  packed slot notes; slot i occupies [i*NOTE_W +: NOTE_W]
- active  output  NUM_VOICES  slot i sounding
- done  output  1  one-cycle pulse when an event commits
- done_voice  output  $clog2(NUM_VOICES)  slot affected; valid while done=1
- stolen  output  1  one-cycle pulse, coincident with done, when note-on stole a busy slot

Behaviour:
- Reset (async, any state, including mid-scan): state=IDLE, notes=0, active=0, steal_ptr=0, done=0, stolen=0, done_voice=0, event_ready=0 until the first clock after reset deasserts; any captured event is discarded.
- States: IDLE, SCAN, COMMIT.
- IDLE: event_ready=1. On event_valid && event_ready, capture event_on/event_note, idx=0, clear match/free flags, go to SCAN.
- SCAN: event_ready=0; lasts exactly NUM_VOICES cycles, examining slot idx each cycle.
  - Record the lowest slot with active=1 && notes==event_note as match.
  - Record the lowest slot with active=0 as free.
  - At idx==NUM_VOICES-1, go to COMMIT.
- COMMIT: one cycle; outputs update at the end of this cycle, then go to IDLE. done=1 during the cycle after COMMIT's edge.
- Latency: NUM_VOICES+2 edges from the accept edge to done. Throughput: one event per NUM_VOICES+2 cycles.
- Note-on target priority:
  1. match slot: retrigger, note unchanged, active stays 1.
  2. Else lowest free slot.
  3. Else steal_ptr slot: stolen=1, and steal_ptr increments modulo NUM_VOICES.
- Note-on writes the target slot: notes[target]=event_note, active[target]=1.
- Note-off:
  - If a match exists, active[match]=0; notes retains its value.
  - If no match, no state change; done still pulses, with done_voice=0 and stolen=0.
- steal_ptr changes only on a steal.
- Duplicate notes never coexist as active slots.
- event_note is held by the allocator; the source may change inputs after the handshake.

Optional Feature:
- Macro: POLY_SUSTAIN_EN.
- With the macro, an added input sustain (1 bit) and a per-slot held bit are present.
  - Note-off match while sustain=1: held[match]=1; active stays 1.
  - In any IDLE cycle with sustain=0: all held slots get active=0 and held=0.
  - This release may coincide with an event accept; both take effect.
  - Note-on retrigger or steal of a slot clears its held bit.
  - Reset clears held.
- Without the macro: no sustain port, no held storage; note-off always clears immediately.

Decomposition:
- Shared package poly_synth_pkg:
  - NUM_VOICES, NOTE_W, VOICE_IDX_W.
  - State enum {IDLE, SCAN, COMMIT}.
  - The note typedef shared with the frequency lookup.
- One natural sub-module, poly_voice_slot:
  - Per-slot note/active/held register.
  - Write-enable, set, clear and release inputs.
  - Instantiated NUM_VOICES times.

Test Plan:
- Reset, then note-on 60 → done after 18 edges; done_voice=0, notes[0]=60, active=16'h0001, stolen=0.
- Note-ons 60, 64, 67, then note-off 64 → active=16'h0005; notes[1] still 64. Then note-on 72 → done_voice=1, notes[1]=72.
- Note-on 60 twice → second gives done_voice=0 (retrigger); active has a single bit set.
- 17 distinct note-ons 0..16 → 17th: stolen=1, done_voice=0, notes[0]=16. An 18th, note 20, steals slot 1.
- Note-off 99 with no match → done=1, active unchanged, done_voice=0. Reset asserted mid-SCAN → active=0, event_ready=1 one clock after release.
- With POLY_SUSTAIN_EN: sustain=1, note-on 60, note-off 60 → active[0] stays 1. Drop sustain in IDLE → active[0]=0 next edge.
